// File: rtl/regfile_bypass_sb.sv
// 2-read/2-write register file with same-cycle write-to-read bypass and a
// per-register busy scoreboard for WAW/RAW tracking in the pipelined core.
module regfile_bypass_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we0,
  input  logic [AW-1:0]   waddr0,
  input  logic [XLEN-1:0] wdata0,
  input  logic            we1,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata1,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_stall,
  input  logic [AW-1:0]   debug_addr,
  output logic [XLEN-1:0] debug_data,
  output logic            debug_busy
);

  localparam int unsigned NREGS = 2 ** AW;
  localparam bit          ZR    = (ZERO_REG != 0);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] clr_vec;
  logic             wen0;
  logic             wen1;
  logic             stall_int;
  logic             issue_acc;

  // Bypassed read: x0 hardwired, then port 1 (younger), then port 0, then array.
  function automatic logic [XLEN-1:0] rd_byp(input logic [AW-1:0] a);
    if (ZR && (a == '0))                return '0;
    else if (we1 && (waddr1 == a))      return wdata1;
    else if (we0 && (waddr0 == a))      return wdata0;
    else                                return regs_q[a];
  endfunction

  // Effective write enables; writes to x0 are dropped when it is hardwired.
  always_comb begin
    wen0 = we0 && !(ZR && (waddr0 == '0));
    wen1 = we1 && !(ZR && (waddr1 == '0));
  end

  // Next array contents; port 1 applied last so it wins on an address collision.
  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (wen0) regs_d[waddr0] = wdata0;
    if (wen1) regs_d[waddr1] = wdata1;
  end

  // Per-register writeback-clear vector.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NREGS; i++) begin
      clr_vec[i] = (we0 && (waddr0 == AW'(i))) || (we1 && (waddr1 == AW'(i)));
    end
  end

  // WAW stall unless the pending producer retires this very cycle.
  always_comb begin
    stall_int = issue_valid && busy_q[issue_rd] && !clr_vec[issue_rd]
                && !(ZR && (issue_rd == '0));
    issue_acc = issue_valid && !stall_int;
  end

  // Scoreboard update: a new issue outranks a same-cycle retire.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREGS; i++) begin
      if (issue_acc && (issue_rd == AW'(i))) busy_d[i] = 1'b1;
      else if (clr_vec[i])                   busy_d[i] = 1'b0;
    end
    if (ZR) busy_d[0] = 1'b0;
  end

  // Array and scoreboard state; asynchronous clear on rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      busy_q <= busy_d;
    end
  end

  // Combinational outputs, forced to zero while reset is held.
  always_comb begin
    rs1_data    = '0;
    rs2_data    = '0;
    rs1_busy    = 1'b0;
    rs2_busy    = 1'b0;
    issue_stall = 1'b0;
    debug_data  = '0;
    debug_busy  = 1'b0;
    if (rst) begin
      rs1_data    = rd_byp(rs1_addr);
      rs2_data    = rd_byp(rs2_addr);
      rs1_busy    = busy_q[rs1_addr] && !clr_vec[rs1_addr];
      rs2_busy    = busy_q[rs2_addr] && !clr_vec[rs2_addr];
      issue_stall = stall_int;
      debug_data  = regs_q[debug_addr];
      debug_busy  = busy_q[debug_addr];
    end
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Scoreboard bench for regfile_bypass_sb: stimulus queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_regfile_bypass_sb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  localparam int S_RS1D = 0, S_RS2D = 1, S_RS1B = 2, S_RS2B = 3,
                 S_STALL = 4, S_DBGD = 5, S_DBGB = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1_addr, rs2_addr, waddr0, waddr1, issue_rd, debug_addr;
  logic [XLEN-1:0] rs1_data, rs2_data, wdata0, wdata1, debug_data;
  logic            rs1_busy, rs2_busy, we0, we1, issue_valid, issue_stall, debug_busy;

  regfile_bypass_sb #(.XLEN(XLEN), .AW(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .debug_addr(debug_addr), .debug_data(debug_data), .debug_busy(debug_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_mis = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_RS1D:  return rs1_data;
      S_RS2D:  return rs2_data;
      S_RS1B:  return {31'b0, rs1_busy};
      S_RS2B:  return {31'b0, rs2_busy};
      S_STALL: return {31'b0, issue_stall};
      S_DBGD:  return debug_data;
      default: return {31'b0, debug_busy};
    endcase
  endfunction

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = actual(mon_e.sel);
      n_cmp++;
      if (mon_act !== mon_e.exp) begin
        n_mis++;
        $display("FAIL %s (cycle %0d): got 0x%08h, required 0x%08h",
                 mon_e.name, mon_e.cyc, mon_act, mon_e.exp);
      end
    end
  end

  task automatic exp_push(input string n, input int s, input logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = s; e.exp = v; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic idle();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    idle();
    rs1_addr = '0; rs2_addr = '0; debug_addr = '0;

    // Power-on reset state
    next_cyc();
    rs1_addr = 5'd3; debug_addr = 5'd3;
    exp_push("por_rs1_data", S_RS1D, 32'h0);
    exp_push("por_stall",    S_STALL, 32'h0);
    exp_push("por_dbg_busy", S_DBGB, 32'h0);
    next_cyc();
    rst = 1'b1;

    // Write x3 with same-cycle read: bypass before the edge, array after
    next_cyc();
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h11;
    rs1_addr = 5'd3; debug_addr = 5'd3;
    exp_push("byp_x3_rs1",    S_RS1D, 32'h11);
    exp_push("byp_x3_dbg_old", S_DBGD, 32'h0);
    next_cyc();
    idle();
    exp_push("arr_x3_dbg",  S_DBGD, 32'h11);
    exp_push("arr_x3_rs1",  S_RS1D, 32'h11);
    exp_push("x3_not_busy", S_DBGB, 32'h0);

    // Dual write to x7: port 1 wins in bypass and array
    next_cyc();
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'hAAAA_0000;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h5555_FFFF;
    rs2_addr = 5'd7;
    exp_push("dual_byp_x7", S_RS2D, 32'h5555_FFFF);
    next_cyc();
    idle();
    debug_addr = 5'd7;
    exp_push("dual_arr_x7", S_DBGD, 32'h5555_FFFF);
    exp_push("dual_rs2_x7", S_RS2D, 32'h5555_FFFF);

    // Split-address dual write: each read port sees its own writer
    next_cyc();
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h0000_0404;
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h0000_0505;
    rs1_addr = 5'd4; rs2_addr = 5'd5;
    exp_push("split_rs1_x4", S_RS1D, 32'h0404);
    exp_push("split_rs2_x5", S_RS2D, 32'h0505);

    // Issue x9, then retire it via port 1
    next_cyc();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    exp_push("iss9_stall", S_STALL, 32'h0);
    next_cyc();
    idle();
    rs2_addr = 5'd9; debug_addr = 5'd9;
    exp_push("x9_rs2_busy", S_RS2B, 32'h1);
    exp_push("x9_dbg_busy", S_DBGB, 32'h1);
    next_cyc();
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h42;
    exp_push("wb9_rs2_busy", S_RS2B, 32'h0);
    exp_push("wb9_rs2_data", S_RS2D, 32'h42);
    exp_push("wb9_dbg_busy", S_DBGB, 32'h1);
    next_cyc();
    idle();
    exp_push("x9_cleared",  S_DBGB, 32'h0);
    exp_push("x9_arr_data", S_DBGD, 32'h42);

    // WAW: re-issue x9 while busy stalls; with a retiring write it is accepted
    next_cyc();
    issue_valid = 1'b1; issue_rd = 5'd9;
    exp_push("reiss_accept", S_STALL, 32'h0);
    next_cyc();
    issue_valid = 1'b1; issue_rd = 5'd9;
    exp_push("waw_stall",    S_STALL, 32'h1);
    exp_push("waw_dbg_busy", S_DBGB, 32'h1);
    next_cyc();
    issue_valid = 1'b1; issue_rd = 5'd9;
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h77;
    exp_push("waw_wb_stall", S_STALL, 32'h0);
    exp_push("waw_wb_rs2b",  S_RS2B, 32'h0);
    exp_push("waw_wb_rs2d",  S_RS2D, 32'h77);
    next_cyc();
    idle();
    exp_push("set_beats_clr", S_DBGB, 32'h1);
    exp_push("x9_data_77",    S_DBGD, 32'h77);
    exp_push("x9_rs2_busy2",  S_RS2B, 32'h1);

    // Hardwired x0: ignores writes and issues
    next_cyc();
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    rs1_addr = 5'd0;
    exp_push("x0_rs1_data", S_RS1D, 32'h0);
    exp_push("x0_rs1_busy", S_RS1B, 32'h0);
    exp_push("x0_stall",    S_STALL, 32'h0);
    next_cyc();
    idle();
    debug_addr = 5'd0;
    exp_push("x0_arr_data", S_DBGD, 32'h0);
    exp_push("x0_arr_busy", S_DBGB, 32'h0);

    // Mid-run reset: x9 busy, x3 holds data, writes and issue pending
    next_cyc();
    rs1_addr = 5'd3; rs2_addr = 5'd9; debug_addr = 5'd9;
    we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h99;
    issue_valid = 1'b1; issue_rd = 5'd9;
    exp_push("pre_rst_stall", S_STALL, 32'h1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    next_cyc();
    exp_push("rst_rs1_data", S_RS1D, 32'h0);
    exp_push("rst_rs2_data", S_RS2D, 32'h0);
    exp_push("rst_rs2_busy", S_RS2B, 32'h0);
    exp_push("rst_stall",    S_STALL, 32'h0);
    exp_push("rst_dbg_data", S_DBGD, 32'h0);
    exp_push("rst_dbg_busy", S_DBGB, 32'h0);
    next_cyc();
    idle();
    rst = 1'b1;
    rs1_addr = 5'd5; rs2_addr = 5'd9; debug_addr = 5'd3;
    exp_push("post_rst_x5",    S_RS1D, 32'h0);
    exp_push("post_rst_x9b",   S_RS2B, 32'h0);
    exp_push("post_rst_x3",    S_DBGD, 32'h0);

    next_cyc();
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
